// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU.
// Each accepted operation takes one EXEC cycle, then its result waits in
// RESP until the owning requester takes it. Ties alternate between ports.

// Combinational ALU: AND, OR, ADD, SUB, SLT.
// ADD/SUB report signed overflow and the adder carry out. For SUB the carry is
// that of A + ~B + 1, so CarryOut=1 means "no borrow" (A >= B unsigned).
// SLT reports the flags of the subtraction it is built on.
// Illegal op codes give Result=0 with both flags low.
module alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            ALUop,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH:0] add_sum;
    logic [DATA_WIDTH:0] sub_diff;
    logic                add_ovf;
    logic                sub_ovf;

    assign add_sum  = {1'b0, A} + {1'b0, B};
    assign sub_diff = {1'b0, A} + {1'b0, ~B} + (DATA_WIDTH + 1)'(1);

    // Signed overflow: operands agree (ADD) or differ (SUB) in sign, result sign flips.
    assign add_ovf = (A[MSB] == B[MSB]) && (add_sum[MSB] != A[MSB]);
    assign sub_ovf = (A[MSB] != B[MSB]) && (sub_diff[MSB] != A[MSB]);

    // Operation select.
    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves it unassigned; a missing default here infers a latch.
        Result   = '0;
        Overflow = 1'b0;
        CarryOut = 1'b0;
        case (ALUop)
            3'b000: Result = A & B;
            3'b001: Result = A | B;
            3'b010: begin
                Result   = add_sum[MSB:0];
                Overflow = add_ovf;
                CarryOut = add_sum[DATA_WIDTH];
            end
            3'b110: begin
                Result   = sub_diff[MSB:0];
                Overflow = sub_ovf;
                CarryOut = sub_diff[DATA_WIDTH];
            end
            3'b111: begin
                // Sign of the true difference, corrected for overflow.
                Result   = {{(DATA_WIDTH - 1){1'b0}}, sub_diff[MSB] ^ sub_ovf};
                Overflow = sub_ovf;
                CarryOut = sub_diff[DATA_WIDTH];
            end
            default: ;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    output logic                  req0_ready,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req0_A,
    input  logic [DATA_WIDTH-1:0] req0_B,
    input  logic [DATA_WIDTH-1:0] req1_A,
    input  logic [DATA_WIDTH-1:0] req1_B,
    input  logic [2:0]            req0_op,
    input  logic [2:0]            req1_op,
    output logic                  resp0_valid,
    output logic                  resp1_valid,
    input  logic                  resp0_ready,
    input  logic                  resp1_ready,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic                  resp_zero,
    output logic                  resp_overflow,
    output logic                  resp_carryout,
    output logic                  resp_err
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] RESP = 2'b10;

    logic [1:0]            state;
    logic                  last_grant;
    logic                  grant_sel;
    logic                  grant_id;
    logic                  accept;
    logic                  resp_take;

    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [2:0]            op_code;
    logic                  op_legal;
    logic                  op_logic;

    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic                  alu_overflow;
    logic                  alu_carryout;

    logic [DATA_WIDTH-1:0] res_result;
    logic                  res_zero;
    logic                  res_overflow;
    logic                  res_carryout;
    logic                  res_err;

    // Round-robin pick: a lone valid wins; on a tie the port not granted last wins.
    always_comb begin
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant;
        end else if (req1_valid) begin
            grant_sel = 1'b1;
        end
    end

    // Ready only while idle and out of reset, so at most one port sees it.
    assign req0_ready = (state == IDLE) && !rst && req0_valid && !grant_sel;
    assign req1_ready = (state == IDLE) && !rst && req1_valid &&  grant_sel;
    assign accept     = req0_ready || req1_ready;

    // Only the owner of the pending result can release it.
    assign resp_take  = grant_id ? resp1_ready : resp0_ready;

    assign resp0_valid   = (state == RESP) && !grant_id;
    assign resp1_valid   = (state == RESP) &&  grant_id;
    assign resp_result   = res_result;
    assign resp_zero     = res_zero;
    assign resp_overflow = res_overflow;
    assign resp_carryout = res_carryout;
    assign resp_err      = res_err;

    // Classify the latched op code: legal set, and the logic ops with no arithmetic flags.
    always_comb begin
        op_legal = 1'b0;
        case (op_code)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_legal = 1'b1;
            default: ;
        endcase
        op_logic = (op_code[2:1] == 2'b00);
    end

    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .A        (op_a),
        .B        (op_b),
        .ALUop    (op_code),
        .Overflow (alu_overflow),
        .CarryOut (alu_carryout),
        .Zero     (alu_zero),
        .Result   (alu_result)
    );

    // Control FSM with operand and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant_id     <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            op_code      <= '0;
            res_result   <= '0;
            res_zero     <= 1'b0;
            res_overflow <= 1'b0;
            res_carryout <= 1'b0;
            res_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values; blocking ones would let later lines see new state.
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a       <= grant_sel ? req1_A  : req0_A;
                        op_b       <= grant_sel ? req1_B  : req0_B;
                        op_code    <= grant_sel ? req1_op : req0_op;
                        grant_id   <= grant_sel;
                        last_grant <= grant_sel;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    res_err      <= !op_legal;
                    res_result   <= op_legal ? alu_result : '0;
                    res_zero     <= op_legal ? alu_zero : 1'b1;
                    res_overflow <= op_legal && !op_logic && alu_overflow;
                    res_carryout <= op_legal && !op_logic && alu_carryout;
                    state        <= RESP;
                end
                RESP: begin
                    if (resp_take) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed operations with literal expectations plus a
// transaction-level model compared against the outputs on every falling edge.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 1;

    typedef struct packed {
        logic [DW-1:0] result;
        logic          zero;
        logic          ovf;
        logic          cry;
        logic          err;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [DW-1:0] req0_A, req0_B, req1_A, req1_B;
    logic [2:0]    req0_op, req1_op;
    logic          resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [DW-1:0] resp_result;
    logic          resp_zero, resp_overflow, resp_carryout, resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_valid    (req0_valid),
        .req1_valid    (req1_valid),
        .req0_ready    (req0_ready),
        .req1_ready    (req1_ready),
        .req0_A        (req0_A),
        .req0_B        (req0_B),
        .req1_A        (req1_A),
        .req1_B        (req1_B),
        .req0_op       (req0_op),
        .req1_op       (req1_op),
        .resp0_valid   (resp0_valid),
        .resp1_valid   (resp1_valid),
        .resp0_ready   (resp0_ready),
        .resp1_ready   (resp1_ready),
        .resp_result   (resp_result),
        .resp_zero     (resp_zero),
        .resp_overflow (resp_overflow),
        .resp_carryout (resp_carryout),
        .resp_err      (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected response from plain signed/unsigned arithmetic.
    function automatic resp_t alu_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [2:0] op);
        resp_t  r;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'(a);
        longint ub = longint'(b);
        r = '0;
        case (op)
            3'b000: r.result = a & b;
            3'b001: r.result = a | b;
            3'b010: begin
                r.result = a + b;
                r.ovf    = (sa + sb > SMAX) || (sa + sb < SMIN);
                r.cry    = (ua + ub) > 64'hFFFF_FFFF;
            end
            3'b110, 3'b111: begin
                r.result = (op == 3'b110) ? a - b : ((sa < sb) ? 32'd1 : 32'd0);
                r.ovf    = (sa - sb > SMAX) || (sa - sb < SMIN);
                r.cry    = (ua >= ub);
            end
            default: r.err = 1'b1;
        endcase
        r.zero = (r.result == 0);
        return r;
    endfunction

    // Transaction model: idle flag via m_since (-1 idle, 1 executing, 2 result pending).
    int    m_since = -1;
    bit    m_last  = 1'b1;
    bit    m_port  = 1'b0;
    resp_t m_resp  = '0;

    always @(negedge clk) begin
        bit g, e_r0, e_r1;
        if (rst) begin
            check("rst_req0_ready",  req0_ready,  0);
            check("rst_req1_ready",  req1_ready,  0);
            check("rst_resp0_valid", resp0_valid, 0);
            check("rst_resp1_valid", resp1_valid, 0);
            check("rst_result",      resp_result, 0);
            check("rst_flags", {resp_zero, resp_overflow, resp_carryout, resp_err}, 0);
            m_since = -1;
            m_last  = 1'b1;
        end else begin
            g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e_r0 = (m_since < 0) && req0_valid && !g;
            e_r1 = (m_since < 0) && req1_valid &&  g;
            check("m_req0_ready",  req0_ready,  e_r0);
            check("m_req1_ready",  req1_ready,  e_r1);
            check("m_resp0_valid", resp0_valid, (m_since >= 2) && !m_port);
            check("m_resp1_valid", resp1_valid, (m_since >= 2) &&  m_port);
            if (m_since >= 2) begin
                check("m_result",   resp_result,   m_resp.result);
                check("m_zero",     resp_zero,     m_resp.zero);
                check("m_overflow", resp_overflow, m_resp.ovf);
                check("m_carryout", resp_carryout, m_resp.cry);
                check("m_err",      resp_err,      m_resp.err);
            end
            if (e_r0 || e_r1) begin
                m_since = 1;
                m_port  = g;
                m_last  = g;
                m_resp  = g ? alu_model(req1_A, req1_B, req1_op)
                            : alu_model(req0_A, req0_B, req0_op);
            end else if (m_since == 1) begin
                m_since = 2;
            end else if (m_since >= 2 && (m_port ? resp1_ready : resp0_ready)) begin
                m_since = -1;
            end
        end
    end

    task automatic drive(input bit port, input bit v, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [2:0] op);
        if (port) begin
            req1_valid = v; req1_A = a; req1_B = b; req1_op = op;
        end else begin
            req0_valid = v; req0_A = a; req0_B = b; req0_op = op;
        end
    endtask

    task automatic wait_ready(input bit port, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            cyc++;
            if (port ? req1_ready : req0_ready) ok = 1'b1;
        end
    endtask

    task automatic wait_resp(input bit port, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            cyc++;
            if (port ? resp1_valid : resp0_valid) ok = 1'b1;
        end
    endtask

    // One operation with resp_ready high; checks latency and literal results.
    task automatic do_op(input string name, input bit port, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [2:0] op,
                         input logic [DW-1:0] e_res, input bit e_z, input bit e_v,
                         input bit e_c, input bit e_e);
        bit ok;
        int cyc;
        @(posedge clk); #1;
        drive(port, 1'b1, a, b, op);
        wait_ready(port, ok, cyc);
        check({name, "_accept"}, ok, 1);
        @(posedge clk); #1;
        drive(port, 1'b0, '0, '0, '0);
        wait_resp(port, ok, cyc);
        check({name, "_latency"}, cyc, 2);
        check({name, "_result"}, resp_result, e_res);
        check({name, "_flags"}, {resp_zero, resp_overflow, resp_carryout, resp_err},
              {e_z, e_v, e_c, e_e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int cyc;
        int n_g;
        bit grants[4];

        rst = 1'b1;
        drive(0, 1'b1, 32'd1, 32'd1, 3'b010);
        drive(1, 1'b1, 32'd1, 32'd1, 3'b010);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ready_gated", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);

        do_op("add_5_3",      0, 32'd5,          32'd3,          3'b010, 32'd8,          0, 0, 0, 0);
        do_op("and_mix",      1, 32'h0000_F0F0,  32'h0000_0FF0,  3'b000, 32'h0000_00F0,  0, 0, 0, 0);
        do_op("and_zero",     1, 32'h0000_00F0,  32'h0000_000F,  3'b000, 32'd0,          1, 0, 0, 0);
        do_op("or_mix",       1, 32'h0000_F0F0,  32'h0000_0FF0,  3'b001, 32'h0000_FFF0,  0, 0, 0, 0);
        do_op("add_ovf",      0, 32'h7FFF_FFFF,  32'd1,          3'b010, 32'h8000_0000,  0, 1, 0, 0);
        do_op("add_carry",    0, 32'hFFFF_FFFF,  32'd1,          3'b010, 32'd0,          1, 0, 1, 0);
        do_op("sub_borrow",   1, 32'd3,          32'd5,          3'b110, 32'hFFFF_FFFE,  0, 0, 0, 0);
        do_op("sub_ovf",      0, 32'h8000_0000,  32'd1,          3'b110, 32'h7FFF_FFFF,  0, 1, 1, 0);
        do_op("slt_true",     0, 32'hFFFF_FFFF,  32'd1,          3'b111, 32'd1,          0, 0, 1, 0);
        do_op("slt_false",    1, 32'd1,          32'hFFFF_FFFF,  3'b111, 32'd0,          1, 0, 0, 0);
        do_op("illegal_100",  0, 32'd5,          32'd5,          3'b100, 32'd0,          1, 0, 0, 1);
        do_op("illegal_011",  1, 32'd1,          32'd2,          3'b011, 32'd0,          1, 0, 0, 1);

        // Tie, back to back: last grant was port 1, so port 0 leads.
        @(posedge clk); #1;
        drive(0, 1'b1, 32'd1, 32'd1, 3'b010);
        drive(1, 1'b1, 32'd2, 32'd4, 3'b001);
        n_g = 0;
        for (int i = 0; i < 40 && n_g < 4; i++) begin
            @(negedge clk);
            if (resp0_valid && resp1_valid) check("tie_resp_exclusive", 1, 0);
            if (req0_ready || req1_ready) begin
                grants[n_g] = req1_ready;
                n_g++;
            end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        check("tie_count", n_g, 4);
        for (int i = 0; i < 4; i++) check($sformatf("tie_grant%0d", i), grants[i], i % 2);
        repeat (4) @(negedge clk);

        // Backpressure on port 1 while port 0 waits.
        resp1_ready = 1'b0;
        @(posedge clk); #1;
        drive(1, 1'b1, 32'd7, 32'd7, 3'b110);
        wait_ready(1, ok, cyc);
        check("bp_accept", ok, 1);
        @(posedge clk); #1;
        drive(1, 1'b0, '0, '0, '0);
        drive(0, 1'b1, 32'd2, 32'd2, 3'b010);
        wait_resp(1, ok, cyc);
        check("bp_resp_seen", ok, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_hold_valid", resp1_valid, 1);
            check("bp_req0_blocked", req0_ready, 0);
            check("bp_result", resp_result, 0);
            check("bp_zero", resp_zero, 1);
        end
        @(posedge clk); #1;
        resp1_ready = 1'b1;
        wait_ready(0, ok, cyc);
        check("bp_req0_after_release", ok, 1);
        @(posedge clk); #1;
        drive(0, 1'b0, '0, '0, '0);
        wait_resp(0, ok, cyc);
        check("bp_req0_result", resp_result, 32'd4);

        // Reset while a result is pending: response vanishes at once.
        resp1_ready = 1'b0;
        @(posedge clk); #1;
        drive(1, 1'b1, 32'd9, 32'd9, 3'b010);
        wait_ready(1, ok, cyc);
        @(posedge clk); #1;
        drive(1, 1'b0, '0, '0, '0);
        wait_resp(1, ok, cyc);
        check("rr_resp_seen", ok, 1);
        #2;
        rst = 1'b1;
        drive(0, 1'b1, 32'd3, 32'd3, 3'b010);
        drive(1, 1'b1, 32'd6, 32'd1, 3'b110);
        #1;
        check("rr_async_valid", {resp0_valid, resp1_valid}, 0);
        check("rr_async_ready", {req0_ready, req1_ready}, 0);
        check("rr_async_result", resp_result, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        resp1_ready = 1'b1;
        @(negedge clk);
        check("rr_tie_after_reset", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk); #1;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_no_stale_resp1", resp1_valid, 0);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
